mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU's data-memory bus; the responder for the core's MemRead/MemWrite/addr/din/dout initiator.
- Decodes a 16-byte window at BASE_ADDR.
- Buffers written bytes in a small FIFO and serialises them 8N1 on a tx pin.
- Sits beside the data memory in the top level; its dout is ORed/muxed with memory dout using the sel output.

Parameters:
BASE_ADDR, 32'hFFFF_FC00, byte address of register window (aligned to 16 bytes)
FIFO_DEPTH, 4, transmit FIFO entries (power of two, >=2)
DEFAULT_DIV, 16'd868, reset value of baud divisor (clk cycles per bit)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
MemRead  input  1  CPU load strobe
MemWrite  input  1  CPU store strobe
addr  input  32  byte address from ALUResult
din  input  32  store data (ReadData2)
dout  output  32  load data; combinational from registered state
sel  output  1  high when addr hits window (addr[31:4]==BASE_ADDR[31:4])
tx  output  1  serial line, registered, idles high

Behaviour:
- Register map, offset addr[3:2]; addr[1:0] ignored:
  - 0x0 TXDATA: W pushes din[7:0]; reads 0.
  - 0x4 STATUS: R, bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[6:4] count, others 0. W with din[3]=1 clears overflow; other bits ignored.
  - 0x8 BAUDDIV: RW, 16 bits in [15:0]; write of 0 stores 1.
  - 0xC reserved: reads 0, writes ignored.
- dout = 0 when !sel or !MemRead. No wait states; reads reflect state before the current edge.
- Writes take effect at the clock edge where sel&&MemWrite. MemRead and MemWrite together: the write occurs, and dout shows the pre-edge value.
- Reset values: tx=1, FIFO empty (count 0), overflow=0, div=DEFAULT_DIV, FSM IDLE, dout=0 unless a read is in progress. Reset mid-frame aborts the frame; tx=1 on the next cycle; FIFO contents are discarded.
- FIFO:
  - Circular buffer; wr/rd pointers wrap modulo FIFO_DEPTH; count has width clog2(DEPTH)+1.
  - Push to a full FIFO (full sampled before the edge) is dropped and sets overflow, even if a pop happens on the same edge.
  - Simultaneous push and pop when not full: count unchanged.
- FSM IDLE->START->DATA->STOP->IDLE:
  - IDLE: if FIFO non-empty, pop the head into an 8-bit shift register, load the bit counter with div-1, go to START, set tx=0.
  - Every state holds each bit for exactly div cycles.
  - START -> DATA: tx=shift[0], LSB first; after 8 bits go to STOP with tx=1.
  - STOP end -> IDLE. If the FIFO is non-empty at that edge, go directly to START (back-to-back frames with no idle gap), so a frame is 10*div cycles.
- Latency: push at edge N into an empty FIFO with FSM IDLE -> pop and tx=0 at edge N+1.
- BAUDDIV written mid-frame takes effect at the next bit-boundary reload; the current bit keeps its length.

Decomposition:
- Shared include (variables.vh style): `REGWIDTH, register offsets (UART_TXDATA/STATUS/DIV), STATUS bit indices, FSM state encodings.
- One sub-module: uart_tx_fifo (sync FIFO with push/pop/full/empty/count, DEPTH parameter).
- Bus decode, register file and FSM live in mmio_uart_tx.

Test Plan:
1. Reset, then read STATUS at BASE+4 -> dout=32'h4 (empty); tx=1; read BAUDDIV -> 868.
2. Write div=4, store 0xA5 to TXDATA -> tx=0 for 4 cycles starting one cycle after the push, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop 1; busy=1 for 40 cycles.
3. Push 6 bytes back-to-back with div=2 -> first byte popped, 4 queued, 1 dropped; STATUS overflow=1; 5 frames sent contiguously in 100 cycles; write STATUS din=8 clears overflow.
4. Load at addr BASE+0x10 and at a data-memory address -> sel=0, dout=0, no state change; load at BASE+0xC -> 0.
5. Assert rst mid-DATA bit 3 -> tx=1 next cycle, count=0, div=868, no residual bits after release.
6. Write BAUDDIV=0 -> read back 1; a frame takes 10 cycles; a divisor change mid-frame alters only the following bits.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and transmitter state encoding.
package mmio_uart_tx_pkg;

  localparam int REGWIDTH = 32;

  // Word offsets within the window, selected by addr[3:2]
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous circular FIFO holding bytes waiting to be serialised.
// Pushes into a full FIFO and pops from an empty one are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, TXDATA/STATUS/BAUDDIV
// registers and the bit-serialising state machine.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FC00,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        sel,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    offset;
  logic          wr_en;
  logic          rd_en;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   div;
  logic [REGWIDTH-1:0] status;
  logic          unused_bits;

  tx_state_e state, state_n;
  logic [15:0] bit_cnt, bit_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        tx_q, tx_n;
  logic        bit_done;

  assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = addr[3:2];
  assign wr_en       = sel && MemWrite;
  assign rd_en       = sel && MemRead;
  assign push        = wr_en && (offset == UART_TXDATA);
  assign unused_bits = ^{addr[1:0], din[31:16]};
  assign tx          = tx_q;
  assign bit_done    = (bit_cnt == 16'd0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (din[7:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A zero divisor would never finish a bit, so it is stored as one
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (push && full) begin
        overflow <= 1'b1;
      end else if (wr_en && (offset == UART_STATUS) && din[STAT_OVF]) begin
        overflow <= 1'b0;
      end
      if (wr_en && (offset == UART_DIV)) begin
        div <= (din[15:0] == 16'd0) ? 16'd1 : din[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
    end
  end

  // Each bit lasts div cycles; the divisor is sampled only at bit reloads,
  // and the end of a stop bit chains straight into the next start bit.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_n   = head;
          bit_cnt_n = div - 16'd1;
          state_n   = START;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          tx_n      = shift[0];
          bit_idx_n = 3'd0;
          bit_cnt_n = div - 16'd1;
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_n = div - 16'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            tx_n      = shift[1];
            shift_n   = {1'b0, shift[7:1]};
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!empty) begin
            pop       = 1'b1;
            shift_n   = head;
            bit_cnt_n = div - 16'd1;
            state_n   = START;
            tx_n      = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_comb begin
    status = '0;
    status[STAT_BUSY]            = (state != IDLE);
    status[STAT_FULL]            = full;
    status[STAT_EMPTY]           = empty;
    status[STAT_OVF]             = overflow;
    status[STAT_CNT_LSB +: 3]    = 3'(count);
    dout = '0;
    if (rd_en) begin
      case (offset)
        UART_STATUS: dout = status;
        UART_DIV:    dout = {16'd0, div};
        default:     dout = '0;
      endcase
    end
  end

endmodule
